// File: rtl/sprite_draw_scheduler_pkg.sv
// Sprite draw scheduler shared definitions.
// Holds the queued descriptor layout, the scheduler state encoding and the
// default queue depth used by the interface, the queue and the top level.
package sprite_sched_pkg;

  localparam int DEPTH_DEFAULT = 16;

  // One sprite as captured from the PIO (112 bits).
  typedef struct packed {
    logic [15:0] id;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] width;
    logic [15:0] height;
    logic [31:0] address;
  } sprite_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_t;

  // Saturating 8-bit increment for the missed-swap counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// Sprite draw scheduler bus.
// Groups the PIO descriptor inputs, VGA vsync, the sprite controller
// handshake and the status outputs.
//   master : drives pio_*, vga_vs, done_draw; observes everything else
//   slave  : the scheduler itself
interface sprite_draw_scheduler_if #(
  parameter int DEPTH = sprite_sched_pkg::DEPTH_DEFAULT
);
  import sprite_sched_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   pio_sprite_id;
  logic [15:0]   pio_x;
  logic [15:0]   pio_y;
  logic [15:0]   pio_width;
  logic [15:0]   pio_height;
  logic [31:0]   pio_address;
  logic          vga_vs;
  logic          done_draw;

  logic          draw_sprite;
  logic [15:0]   sprite_id;
  logic [15:0]   sprite_x;
  logic [15:0]   sprite_y;
  logic [15:0]   sprite_width;
  logic [15:0]   sprite_height;
  logic [31:0]   sprite_address;
  logic          swap_frame;
  logic [CW-1:0] queue_count;
  logic          overflow;
  logic [7:0]    missed_swaps;

  modport master (
    output pio_sprite_id, pio_x, pio_y, pio_width, pio_height, pio_address,
    output vga_vs, done_draw,
    input  draw_sprite, sprite_id, sprite_x, sprite_y, sprite_width,
    input  sprite_height, sprite_address, swap_frame, queue_count,
    input  overflow, missed_swaps
  );

  modport slave (
    input  pio_sprite_id, pio_x, pio_y, pio_width, pio_height, pio_address,
    input  vga_vs, done_draw,
    output draw_sprite, sprite_id, sprite_x, sprite_y, sprite_width,
    output sprite_height, sprite_address, swap_frame, queue_count,
    output overflow, missed_swaps
  );

endinterface

// File: rtl/sprite_draw_scheduler_fifo.sv
// Sprite descriptor queue: single-clock FIFO with a registered head output.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   push_i/wdata_i write a descriptor (ignored when full)
//   pop_i          load the head into rdata_o (ignored when empty)
//   rdata_o        registered last-popped descriptor
//   count_o        number of stored descriptors
//   full_o/empty_o occupancy flags
module sprite_desc_fifo
  import sprite_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  sprite_desc_t           wdata_i,
  input  logic                   pop_i,
  output sprite_desc_t           rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  sprite_desc_t mem_q [DEPTH];
  sprite_desc_t rdata_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata_q  <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;
  assign count_o = count_q;

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Sprite draw scheduler.
// Captures sprite descriptors from the Nios PIO whenever the sprite id
// changes, queues them, and hands them one at a time to the sprite
// controller. On each vsync falling edge the frame buffer is swapped only if
// nothing is queued or in flight; otherwise the swap is counted as missed.
// Ports:
//   clk_i  system clock
//   rst_ni asynchronous active-low reset
//   bus    sprite_draw_scheduler_if.slave (PIO, vsync, controller, status)
module sprite_draw_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  sprite_draw_scheduler_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  sched_state_t  state_q, state_d;
  logic [15:0]   last_id_q;
  logic          push;
  logic          pop;
  sprite_desc_t  push_desc;
  sprite_desc_t  head_desc;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          issued_q;
  logic          draw_q;
  logic          swap_q, swap_d;
  logic          overflow_q;
  logic [7:0]    missed_q, missed_d;
  logic          vs_s1_q, vs_s2_q, vs_s3_q;
  logic          vs_fall_q;

  assign push = (bus.pio_sprite_id != last_id_q);
  assign push_desc = '{id:      bus.pio_sprite_id,
                       x:       bus.pio_x,
                       y:       bus.pio_y,
                       width:   bus.pio_width,
                       height:  bus.pio_height,
                       address: bus.pio_address};

  sprite_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_desc),
    .pop_i   (pop),
    .rdata_o (head_desc),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // IDLE looks at the registered count, so a descriptor pushed this cycle
  // is issued no earlier than the next one.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        pop     = 1'b1;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.done_draw) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Swap decision uses the registered state and count, i.e. the view from
  // before any push or issue happening in the same cycle.
  always_comb begin
    swap_d   = 1'b0;
    missed_d = missed_q;
    if (vs_fall_q) begin
      if (state_q == ST_IDLE && fifo_empty) swap_d = 1'b1;
      else                                  missed_d = sat_inc8(missed_q);
    end
  end

  // The head register fills at the end of ISSUE; draw_sprite follows one
  // cycle later so the controller always sees a stable descriptor.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      last_id_q  <= 16'h0000;
      issued_q   <= 1'b0;
      draw_q     <= 1'b0;
      swap_q     <= 1'b0;
      overflow_q <= 1'b0;
      missed_q   <= 8'd0;
      vs_s1_q    <= 1'b1;
      vs_s2_q    <= 1'b1;
      vs_s3_q    <= 1'b1;
      vs_fall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= (state_q == ST_ISSUE);
      draw_q   <= issued_q;
      swap_q   <= swap_d;
      missed_q <= missed_d;
      if (push) begin
        last_id_q <= bus.pio_sprite_id;
        if (fifo_full) overflow_q <= 1'b1;
      end
      vs_s1_q   <= bus.vga_vs;
      vs_s2_q   <= vs_s1_q;
      vs_s3_q   <= vs_s2_q;
      vs_fall_q <= vs_s3_q & ~vs_s2_q;
    end
  end

  assign bus.draw_sprite    = draw_q;
  assign bus.sprite_id      = head_desc.id;
  assign bus.sprite_x       = head_desc.x;
  assign bus.sprite_y       = head_desc.y;
  assign bus.sprite_width   = head_desc.width;
  assign bus.sprite_height  = head_desc.height;
  assign bus.sprite_address = head_desc.address;
  assign bus.swap_frame     = swap_q;
  assign bus.queue_count    = fifo_count;
  assign bus.overflow       = overflow_q;
  assign bus.missed_swaps   = missed_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed testbench for sprite_draw_scheduler (queue depth 4).
module tb_sprite_draw_scheduler;
  import sprite_sched_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sprite_draw_scheduler_if #(.DEPTH(DEPTH)) bus ();

  sprite_draw_scheduler #(.DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;
  int cycleNum   = 0;
  int drawPulses = 0;
  int swapPulses = 0;

  always @(negedge clk) begin
    if (bus.draw_sprite === 1'b1) drawPulses++;
    if (bus.swap_frame === 1'b1) swapPulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cycleNum++;
  endtask

  task automatic applyStimulus(input logic [15:0] id, input logic [15:0] x,
                               input logic [15:0] y, input logic [15:0] w,
                               input logic [15:0] h, input logic [31:0] addr);
    bus.pio_sprite_id = id;
    bus.pio_x         = x;
    bus.pio_y         = y;
    bus.pio_width     = w;
    bus.pio_height    = h;
    bus.pio_address   = addr;
  endtask

  task automatic pulseDone();
    bus.done_draw = 1'b1;
    step();
    bus.done_draw = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitDraw(input string tag, input int budget, output int atCycle);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (bus.draw_sprite === 1'b1) seen = 1'b1;
    end
    atCycle = cycleNum;
    checkOutput({tag, " draw seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tPrev;
    int tNow;
    int d0;
    int s0;

    // Reset state
    rst_n         = 1'b0;
    bus.vga_vs    = 1'b1;
    bus.done_draw = 1'b0;
    applyStimulus(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
    step();
    step();
    checkOutput("reset draw_sprite", 32'(bus.draw_sprite), 32'd0);
    checkOutput("reset swap_frame", 32'(bus.swap_frame), 32'd0);
    checkOutput("reset queue_count", 32'(bus.queue_count), 32'd0);
    checkOutput("reset overflow", 32'(bus.overflow), 32'd0);
    checkOutput("reset missed_swaps", 32'(bus.missed_swaps), 32'd0);
    checkOutput("reset sprite_id", 32'(bus.sprite_id), 32'd0);
    checkOutput("reset sprite_address", bus.sprite_address, 32'd0);
    rst_n = 1'b1;
    step();
    checkOutput("release draw_sprite", 32'(bus.draw_sprite), 32'd0);
    checkOutput("release queue_count", 32'(bus.queue_count), 32'd0);

    // Single descriptor: exact issue latency
    applyStimulus(16'd5, 16'd10, 16'd20, 16'd16, 16'd16, 32'h0010_0000);
    step();
    checkOutput("single count=1", 32'(bus.queue_count), 32'd1);
    checkOutput("single no draw c1", 32'(bus.draw_sprite), 32'd0);
    step();
    checkOutput("single no draw c2", 32'(bus.draw_sprite), 32'd0);
    step();
    checkOutput("single outputs x", 32'(bus.sprite_x), 32'd10);
    checkOutput("single no draw c3", 32'(bus.draw_sprite), 32'd0);
    checkOutput("single popped count", 32'(bus.queue_count), 32'd0);
    step();
    checkOutput("single draw pulse", 32'(bus.draw_sprite), 32'd1);
    checkOutput("single sprite_id", 32'(bus.sprite_id), 32'd5);
    checkOutput("single sprite_y", 32'(bus.sprite_y), 32'd20);
    checkOutput("single sprite_address", bus.sprite_address, 32'h0010_0000);
    step();
    checkOutput("single draw one-cycle", 32'(bus.draw_sprite), 32'd0);
    pulseDone();

    // Three back-to-back ids drawn in order
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(16'(k), 16'(k * 100), 16'(k), 16'd8, 16'd8,
                    32'h0020_0000 + 32'(k) * 32'h100);
      step();
    end
    tPrev = -100;
    for (int k = 1; k <= 3; k++) begin
      waitDraw("order", 20, tNow);
      checkOutput("order sprite_id", 32'(bus.sprite_id), 32'(k));
      checkOutput("order sprite_x", 32'(bus.sprite_x), 32'(k * 100));
      checkOutput("order spacing>=3", 32'((tNow - tPrev) >= 3), 32'd1);
      tPrev = tNow;
      step();
      step();
      step();
      pulseDone();
    end
    step();
    step();
    checkOutput("drained queue_count", 32'(bus.queue_count), 32'd0);

    // Vsync fall while idle and empty: swap four cycles after the edge
    bus.vga_vs = 1'b0;
    step();
    step();
    step();
    checkOutput("idle swap not early", 32'(bus.swap_frame), 32'd0);
    step();
    checkOutput("idle swap pulse", 32'(bus.swap_frame), 32'd1);
    step();
    checkOutput("idle swap one-cycle", 32'(bus.swap_frame), 32'd0);
    checkOutput("idle missed_swaps", 32'(bus.missed_swaps), 32'd0);
    bus.vga_vs = 1'b1;
    repeat (4) step();

    // Vsync fall while waiting for the controller: swap is missed
    applyStimulus(16'd7, 16'd70, 16'd71, 16'd8, 16'd8, 32'h0030_0000);
    waitDraw("vs-wait", 20, tNow);
    checkOutput("vs-wait sprite_id", 32'(bus.sprite_id), 32'd7);
    s0 = swapPulses;
    bus.vga_vs = 1'b0;
    repeat (6) step();
    checkOutput("busy no swap", 32'(swapPulses - s0), 32'd0);
    checkOutput("busy missed_swaps", 32'(bus.missed_swaps), 32'd1);
    bus.vga_vs = 1'b1;
    pulseDone();
    step();
    step();

    // Overflow: first issued, four queued, sixth dropped
    d0 = drawPulses;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(16'(k), 16'(k), 16'(k), 16'd2, 16'd2, 32'(k));
      step();
    end
    checkOutput("full queue_count", 32'(bus.queue_count), 32'd4);
    checkOutput("no overflow yet", 32'(bus.overflow), 32'd0);
    applyStimulus(16'd6, 16'd6, 16'd6, 16'd2, 16'd2, 32'd6);
    step();
    checkOutput("overflow set", 32'(bus.overflow), 32'd1);
    checkOutput("overflow queue_count", 32'(bus.queue_count), 32'd4);
    repeat (4) step();
    checkOutput("overflow first issued", 32'(bus.sprite_id), 32'd1);
    checkOutput("overflow one draw", 32'(drawPulses - d0), 32'd1);
    checkOutput("overflow sticky", 32'(bus.overflow), 32'd1);

    // Reset in WAIT_DONE with three queued
    pulseDone();
    waitDraw("second issue", 20, tNow);
    checkOutput("second sprite_id", 32'(bus.sprite_id), 32'd2);
    checkOutput("three queued", 32'(bus.queue_count), 32'd3);
    bus.pio_sprite_id = 16'd0;
    rst_n = 1'b0;
    #2;
    checkOutput("midreset draw_sprite", 32'(bus.draw_sprite), 32'd0);
    checkOutput("midreset queue_count", 32'(bus.queue_count), 32'd0);
    checkOutput("midreset overflow", 32'(bus.overflow), 32'd0);
    checkOutput("midreset missed_swaps", 32'(bus.missed_swaps), 32'd0);
    checkOutput("midreset sprite_id", 32'(bus.sprite_id), 32'd0);
    checkOutput("midreset sprite_x", 32'(bus.sprite_x), 32'd0);
    checkOutput("midreset sprite_address", bus.sprite_address, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    d0 = drawPulses;
    s0 = swapPulses;
    repeat (8) step();
    checkOutput("post-reset no draw", 32'(drawPulses - d0), 32'd0);
    checkOutput("post-reset no swap", 32'(swapPulses - s0), 32'd0);
    checkOutput("post-reset queue empty", 32'(bus.queue_count), 32'd0);
    applyStimulus(16'd9, 16'd90, 16'd91, 16'd4, 16'd4, 32'h0040_0000);
    waitDraw("post-reset new id", 20, tNow);
    checkOutput("post-reset sprite_id", 32'(bus.sprite_id), 32'd9);
    checkOutput("post-reset sprite_address", bus.sprite_address, 32'h0040_0000);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/sprite_draw_scheduler.md
SPRITE_DRAW_SCHEDULER -- requirements
Module: sprite_draw_scheduler

Interface
REQ-001 Parameter DEPTH SHALL be provided: default 16, descriptor queue depth, power of two, 4..128.
REQ-002 Clk  in  1  system clock (SYS_CLK); the block SHALL use this one clock only.
REQ-003 Reset  in  1  reset, asynchronous and active-low.
REQ-004 pio_sprite_id  in  16  sprite id from the Nios PIO; a change of value marks a new descriptor.
REQ-005 pio_x, pio_y, pio_width, pio_height  in  16 each  descriptor fields from the PIO.
REQ-006 pio_address  in  32  sprite pixel-data base address in SDRAM.
REQ-007 VGA_VS  in  1  VGA vertical sync, active-low, asynchronous to Clk.
REQ-008 done_draw  in  1  one-cycle pulse from the sprite controller when the current sprite is finished.
REQ-009 draw_sprite  out  1  one-cycle pulse that starts the sprite controller.
REQ-010 sprite_id, sprite_x, sprite_y, sprite_width, sprite_height  out  16 each  registered descriptor of the sprite being drawn.
REQ-011 sprite_address  out  32  registered address of the sprite being drawn.
REQ-012 swap_frame  out  1  one-cycle pulse that toggles the frame-buffer select.
REQ-013 queue_count  out  $clog2(DEPTH)+1  number of queued descriptors.
REQ-014 overflow  out  1  sticky flag: a descriptor was dropped.
REQ-015 missed_swaps  out  8  saturating count of vsyncs where no swap was allowed.

Function
REQ-016 Capture: in each cycle where pio_sprite_id != last_id, the block SHALL load last_id <= pio_sprite_id and push all six PIO fields as one descriptor.
REQ-017 A push while queue_count==DEPTH SHALL drop the descriptor and set overflow; last_id SHALL still update. Fullness is evaluated before any same-cycle pop.
REQ-018 States SHALL be IDLE, ISSUE and WAIT_DONE.
REQ-019 IDLE->ISSUE when the queue is non-empty; otherwise the block stays in IDLE. A pop on an empty queue SHALL never occur, and a same-cycle push SHALL not bypass the queue.
REQ-020 ISSUE (one cycle): pop the head, register it onto the sprite_* outputs, pulse draw_sprite, then go to WAIT_DONE. draw_sprite SHALL be high in the cycle after the outputs become valid.
REQ-021 WAIT_DONE->IDLE on done_draw. done_draw in IDLE or ISSUE SHALL be ignored.
REQ-022 Minimum issue-to-issue spacing SHALL be 3 cycles (ISSUE, WAIT_DONE with done_draw, IDLE).
REQ-023 Simultaneous push and pop SHALL leave queue_count unchanged and preserve FIFO order.
REQ-024 VGA_VS SHALL pass through a 2-flop synchronizer, and its falling edge SHALL be detected (vs_fall, 3-cycle latency).
REQ-025 On vs_fall, if state==IDLE and the queue is empty, the block SHALL pulse swap_frame in the next cycle; otherwise it SHALL increment missed_swaps (saturating at 255) and not swap.
REQ-026 A vs_fall coinciding with a push or the IDLE->ISSUE decision SHALL be evaluated on the pre-cycle state and count.
REQ-027 Outputs SHALL change only on posedge Clk.

Reset
REQ-028 While Reset==0, the block SHALL force: state=IDLE, queue empty, queue_count=0, last_id=16'h0000, draw_sprite=0, swap_frame=0, all sprite_* outputs=0, overflow=0, missed_swaps=0, synchronizer flops=1.
REQ-029 Reset mid-draw SHALL discard the queue and the in-flight sprite; no draw_sprite or swap_frame pulse SHALL occur in the first cycle after deassertion.

Structure
REQ-030 Package sprite_sched_pkg SHALL hold the descriptor struct (id, x, y, width, height, address; 112 bits), the state enum and the DEPTH default.
REQ-031 The queue SHALL be a sub-module sprite_desc_fifo (single-clock, registered output, push/pop/count).

Verification
REQ-032 Reset, then pio_sprite_id 0->5 with x=10, y=20, w=16, h=16, addr=32'h0010_0000 -> queue_count=1, then draw_sprite pulse with sprite_x=10 and sprite_address=32'h0010_0000.
REQ-033 Push ids 1,2,3 back-to-back with done_draw 4 cycles after each draw_sprite -> draws in order 1,2,3 with >=3 cycles between pulses; queue_count returns to 0.
REQ-034 DEPTH=4, no done_draw, push ids 1..6 -> first issued, 4 queued, overflow=1 from the sixth id, queue_count=4.
REQ-035 VGA_VS falling while idle and empty -> swap_frame pulse 4 cycles after the edge; while in WAIT_DONE -> no pulse and missed_swaps=1.
REQ-036 Reset asserted in WAIT_DONE with 3 queued -> all outputs 0; no draw_sprite after release until a new id change.
